// File: rtl/uart_bus_master.sv
// UART byte-stream to single 32-bit bus transaction bridge.
// Commands: 'W' A3..A0 D3..D0 -> 'K'; 'R' A3..A0 -> D3..D0; bus timeout -> 'E'.
module uart_bus_master #(
    parameter int unsigned IDLE_TMO = 1_000_000,
    parameter int unsigned BUS_TMO  = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        rx_vld,
    input  logic [7:0]  rx_dat,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic [7:0]  tx_dat,
    output logic        bus_vld,
    input  logic        bus_rdy,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdat,
    input  logic [31:0] bus_rdat,
    output logic        rx_ovr
);

    localparam int unsigned IT_W = (IDLE_TMO > 1) ? $clog2(IDLE_TMO) : 1;
    localparam int unsigned BT_W = (BUS_TMO > 1) ? $clog2(BUS_TMO) : 1;

    localparam logic [IT_W-1:0] IT_MAX = IT_W'(IDLE_TMO - 1);
    localparam logic [BT_W-1:0] BT_MAX = BT_W'(BUS_TMO - 1);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t          state, state_nxt;
    logic            op_wr, op_wr_nxt;
    logic [1:0]      byte_cnt, byte_cnt_nxt;
    logic [IT_W-1:0] idle_tmr, idle_tmr_nxt;
    logic [BT_W-1:0] bus_tmr, bus_tmr_nxt;
    logic [23:0]     resp_sr, resp_sr_nxt;

    logic            tx_vld_nxt;
    logic [7:0]      tx_dat_nxt;
    logic            bus_vld_nxt;
    logic [31:0]     bus_addr_nxt;
    logic [3:0]      bus_we_nxt;
    logic [31:0]     bus_wdat_nxt;
    logic            rx_ovr_nxt;

    // State and datapath registers; reset clears every output at once.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= S_IDLE;
            op_wr    <= 1'b0;
            byte_cnt <= 2'd0;
            idle_tmr <= '0;
            bus_tmr  <= '0;
            resp_sr  <= '0;
            tx_vld   <= 1'b0;
            tx_dat   <= 8'h00;
            bus_vld  <= 1'b0;
            bus_addr <= 32'h0;
            bus_we   <= 4'h0;
            bus_wdat <= 32'h0;
            rx_ovr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            op_wr    <= op_wr_nxt;
            byte_cnt <= byte_cnt_nxt;
            idle_tmr <= idle_tmr_nxt;
            bus_tmr  <= bus_tmr_nxt;
            resp_sr  <= resp_sr_nxt;
            tx_vld   <= tx_vld_nxt;
            tx_dat   <= tx_dat_nxt;
            bus_vld  <= bus_vld_nxt;
            bus_addr <= bus_addr_nxt;
            bus_we   <= bus_we_nxt;
            bus_wdat <= bus_wdat_nxt;
            rx_ovr   <= rx_ovr_nxt;
        end
    end

    // Next-state and next-output logic for the command/bus/response sequence.
    always_comb begin
        state_nxt    = state;
        op_wr_nxt    = op_wr;
        byte_cnt_nxt = byte_cnt;
        idle_tmr_nxt = idle_tmr;
        bus_tmr_nxt  = bus_tmr;
        resp_sr_nxt  = resp_sr;
        tx_vld_nxt   = tx_vld;
        tx_dat_nxt   = tx_dat;
        bus_vld_nxt  = bus_vld;
        bus_addr_nxt = bus_addr;
        bus_we_nxt   = bus_we;
        bus_wdat_nxt = bus_wdat;
        rx_ovr_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                byte_cnt_nxt = 2'd0;
                idle_tmr_nxt = '0;
                if (rx_vld) begin
                    if (rx_dat == CMD_WR) begin
                        op_wr_nxt = 1'b1;
                        state_nxt = S_ADDR;
                    end else if (rx_dat == CMD_RD) begin
                        op_wr_nxt = 1'b0;
                        state_nxt = S_ADDR;
                    end
                end
            end

            S_ADDR, S_DATA: begin
                if (rx_vld) begin
                    idle_tmr_nxt = '0;
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    if (state == S_ADDR) begin
                        bus_addr_nxt = {bus_addr[23:0], rx_dat};
                    end else begin
                        bus_wdat_nxt = {bus_wdat[23:0], rx_dat};
                    end
                    if (byte_cnt == 2'd3) begin
                        if (state == S_ADDR && op_wr) begin
                            state_nxt = S_DATA;
                        end else begin
                            // Bus request goes out the cycle after the last byte.
                            state_nxt   = S_BUS;
                            bus_vld_nxt = 1'b1;
                            bus_we_nxt  = op_wr ? 4'hF : 4'h0;
                            bus_tmr_nxt = '0;
                        end
                    end
                end else if (idle_tmr == IT_MAX) begin
                    state_nxt = S_IDLE;
                end else begin
                    idle_tmr_nxt = idle_tmr + IT_W'(1);
                end
            end

            S_BUS: begin
                rx_ovr_nxt = rx_vld;
                // rdy is checked before the timeout so it wins a tie.
                if (bus_vld && bus_rdy) begin
                    state_nxt   = S_RESP;
                    bus_vld_nxt = 1'b0;
                    bus_we_nxt  = 4'h0;
                    tx_vld_nxt  = 1'b1;
                    if (op_wr) begin
                        tx_dat_nxt   = RSP_OK;
                        byte_cnt_nxt = 2'd0;
                    end else begin
                        tx_dat_nxt   = bus_rdat[31:24];
                        resp_sr_nxt  = bus_rdat[23:0];
                        byte_cnt_nxt = 2'd3;
                    end
                end else if (bus_tmr == BT_MAX) begin
                    state_nxt    = S_RESP;
                    bus_vld_nxt  = 1'b0;
                    bus_we_nxt   = 4'h0;
                    tx_vld_nxt   = 1'b1;
                    tx_dat_nxt   = RSP_ERR;
                    byte_cnt_nxt = 2'd0;
                end else begin
                    bus_tmr_nxt = bus_tmr + BT_W'(1);
                end
            end

            S_RESP: begin
                rx_ovr_nxt = rx_vld;
                if (tx_vld && tx_rdy) begin
                    if (byte_cnt == 2'd0) begin
                        tx_vld_nxt = 1'b0;
                        state_nxt  = S_IDLE;
                    end else begin
                        byte_cnt_nxt = byte_cnt - 2'd1;
                        tx_dat_nxt   = resp_sr[23:16];
                        resp_sr_nxt  = {resp_sr[15:0], 8'h00};
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
